interleaver_buffer: RTL

//  Ping-pong symbol buffer between the interleaver and the QPSK mapper.
//  - Accepts one interleaved bit per cycle together with its permuted index j.
//  - Scatters each bit into the current write bank at address j.
//  - Once a full NCBPS-bit block is collected, drains that bank in natural

---
 rtl/interleaver_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/interleaver_buffer.sv
`default_nettype none
// ============================================================================
// Module      : interleaver_buffer
// Description : Ping-pong bit buffer between the interleaver and the QPSK
//               mapper. Bits are scattered into the write bank at their
//               permuted index. A complete bank is drained in natural order
//               as NCPC-bit symbols while the other bank fills.
//               Optional index checking is enabled by defining
//               INTERLEAVER_BUFFER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module interleaver_buffer #(
  parameter int NCBPS = 192,
  parameter int NCPC  = 2,
  parameter int IW    = $clog2(NCBPS) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            data_in,
  input  logic [IW-1:0]   data_in_index,
  output logic            ready_out,
  output logic            valid_out,
  output logic [NCPC-1:0] data_out,
  input  logic            ready_in,
  output logic            block_start,
  output logic            index_err
);

  localparam int NSYM = NCBPS / NCPC;
  localparam int AW   = $clog2(NCBPS);
  localparam int SW   = (NSYM > 1) ? $clog2(NSYM) : 1;

  localparam logic [AW-1:0] c_LAST_BIT = AW'(NCBPS - 1);
  localparam logic [SW-1:0] c_LAST_SYM = SW'(NSYM - 1);
  localparam logic [IW-1:0] c_DEPTH    = IW'(NCBPS);

  // Storage and control state
  logic [NCBPS-1:0] r_bank [2];
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [1:0]       r_full;
  logic [AW-1:0]    r_wr_cnt;
  logic [SW-1:0]    r_rd_sym;

  logic             w_ready;
  logic             w_valid;
  logic             w_wr_acc;
  logic             w_wr_last;
  logic             w_in_range;
  logic [AW-1:0]    w_wr_addr;
  logic             w_rd_xfer;
  logic             w_rd_last;
  logic [1:0]       w_full_nxt;
  logic [AW-1:0]    w_rd_base;
  logic [NCPC-1:0]  w_rd_slice;
  logic [NCPC-1:0]  w_sym;

  // Handshake decode and bank-full bookkeeping; set and clear target different banks
  always_comb begin
    w_ready    = !r_full[r_wr_bank];
    w_valid    = r_full[r_rd_bank];
    w_wr_acc   = valid_in && w_ready;
    w_in_range = (data_in_index < c_DEPTH);
    w_wr_addr  = data_in_index[AW-1:0];
    w_wr_last  = w_wr_acc && (r_wr_cnt == c_LAST_BIT);
    w_rd_xfer  = w_valid && ready_in;
    w_rd_last  = w_rd_xfer && (r_rd_sym == c_LAST_SYM);
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Symbol extraction: lowest bank address lands in the symbol MSB
  always_comb begin
    w_rd_base  = AW'(r_rd_sym) * AW'(NCPC);
    w_rd_slice = r_bank[r_rd_bank][w_rd_base +: NCPC];
    w_sym      = '0;
    for (int i = 0; i < NCPC; i++) begin
      w_sym[NCPC-1-i] = w_rd_slice[i];
    end
  end

  // Output drive; data is forced to zero whenever no symbol is offered
  always_comb begin
    ready_out   = w_ready;
    valid_out   = w_valid;
    data_out    = w_valid ? w_sym : '0;
    block_start = w_valid && (r_rd_sym == '0);
  end

  // Bank scatter write; out-of-range indices are dropped, contents never reset
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      r_bank[r_wr_bank][w_wr_addr] <= data_in;
    end
  end

  // Pointer and counter state; block boundaries follow the accept count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= '0;
      r_wr_cnt  <= '0;
      r_rd_sym  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= r_wr_cnt + AW'(1);
        end
      end
      if (w_rd_xfer) begin
        if (w_rd_last) begin
          r_rd_sym  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_sym  <= r_rd_sym + SW'(1);
        end
      end
    end
  end

`ifdef INTERLEAVER_BUFFER_CHECK_EN
  logic [NCBPS-1:0] r_mask [2];
  logic [NCBPS-1:0] w_mask_base;
  logic [NCBPS-1:0] w_mask_nxt;
  logic             w_dup;
  logic             r_index_err;

  // Written-mask of the current block; the first write of a block starts it afresh
  always_comb begin
    w_mask_base = (r_wr_cnt == '0) ? '0 : r_mask[r_wr_bank];
    w_mask_nxt  = w_mask_base;
    if (w_in_range) w_mask_nxt[w_wr_addr] = 1'b1;
    w_dup       = w_in_range && w_mask_base[w_wr_addr];
  end

  // Mask storage follows every accepted write
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mask[r_wr_bank] <= w_mask_nxt;
    end
  end

  // Sticky error on out-of-range or repeated index within a block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index_err <= 1'b0;
    end else if (w_wr_acc && (!w_in_range || w_dup)) begin
      r_index_err <= 1'b1;
    end
  end

  assign index_err = r_index_err;
`else
  assign index_err = 1'b0;
`endif

endmodule
`default_nettype wire
